// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side bundle: instruction memory port, redirect input
// and the decode-facing head of the prefetch queue.
interface inst_prefetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Credit-limited instruction prefetch queue between imem and decode.
// Redirects flush the queue and squash responses still in flight.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst,
    inst_prefetch_buffer_if.master bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      mem_q [DEPTH];

    ptr_t        wr_ptr;
    ptr_t        wr_ptr_d;
    ptr_t        rd_ptr;
    ptr_t        rd_ptr_d;
    cnt_t        fifo_count;
    cnt_t        fifo_count_d;
    cnt_t        outstanding;
    cnt_t        outstanding_d;
    cnt_t        discard_cnt;
    cnt_t        discard_cnt_d;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_d;
    logic [31:0] resp_pc;
    logic [31:0] resp_pc_d;
    logic [31:0] target_pc;
    logic [CW:0] credit;

    logic        req;
    logic        accept;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        flush;
    logic        has_head;

    // Queue slots plus in-flight requests never exceed DEPTH,
    // so every response that returns has a slot waiting for it.
    always_comb begin
        target_pc = {bus.redirect_pc[31:2], 2'b00};
        flush     = bus.redirect;
        credit    = {1'b0, fifo_count} + {1'b0, outstanding};
        req       = !rst && !flush &&
                    (credit < (CW+1)'(DEPTH));
        accept    = req && bus.imem_gnt;
        rsp       = bus.imem_rvalid && (outstanding != '0);
        push      = rsp && !flush && (discard_cnt == '0);
        has_head  = (fifo_count != '0);
        pop       = has_head && bus.out_ready && !flush;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc;
        resp_pc_d     = resp_pc;
        wr_ptr_d      = wr_ptr;
        rd_ptr_d      = rd_ptr;
        fifo_count_d  = fifo_count;
        discard_cnt_d = discard_cnt;
        outstanding_d = outstanding + cnt_t'(accept)
                      - cnt_t'(rsp);
        if (flush) begin
            fetch_pc_d    = target_pc;
            resp_pc_d     = target_pc;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fifo_count_d  = '0;
            discard_cnt_d = outstanding - cnt_t'(rsp);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc + 32'd4;
                wr_ptr_d  = wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr + ptr_t'(1);
            end
            fifo_count_d = fifo_count + cnt_t'(push)
                         - cnt_t'(pop);
            // Squashed words still count against outstanding.
            if (rsp && (discard_cnt != '0)) begin
                discard_cnt_d = discard_cnt - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            fetch_pc    <= fetch_pc_d;
            resp_pc     <= resp_pc_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            fifo_count  <= fifo_count_d;
            outstanding <= outstanding_d;
            discard_cnt <= discard_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= '{pc: resp_pc,
                               inst: bus.imem_rdata};
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = has_head;
    assign bus.out_inst  = has_head ? mem_q[rd_ptr].inst : '0;
    assign bus.out_pc    = has_head ? mem_q[rd_ptr].pc   : '0;

    rsp_needs_request: assert property (
        @(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scenario bench for inst_prefetch_buffer with an in-order
// variable-latency memory and a program-order output scoreboard.
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_prefetch_buffer_if bus ();

    inst_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t       pq[$];
    int          cyc      = 0;
    int          last_due = 0;
    int          lat      = 1;
    int          mem_due;
    logic        acc_n    = 1'b0;
    logic [31:0] acc_addr = '0;
    int          tot      = 0;
    int          bad      = 0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory: note the handshake away from the edge, commit it at the edge.
    always @(negedge clk) begin
        acc_n    = (bus.imem_req === 1'b1) && (bus.imem_gnt === 1'b1);
        acc_addr = bus.imem_addr;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (acc_n) begin
            mem_due = cyc + lat - 1;
            if (mem_due <= last_due) mem_due = last_due + 1;
            last_due = mem_due;
            pq.push_back('{mem_due, acc_addr});
        end
        #1;
        if (pq.size() != 0 && pq[0].due == cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = inst_of(pq[0].addr);
            void'(pq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
    end

    task automatic release_rst();
        repeat (2) @(posedge clk);
        @(negedge clk);
        pq.delete();
        last_due = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        release_rst();
    endtask

    task automatic test_reset();
        bus.imem_gnt  = 1'b1;
        bus.out_ready = 1'b1;
        lat = 1;
        #1;
        tot++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst0_req got=%b want=0", bus.imem_req); end
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst0_valid got=%b want=0", bus.out_valid); end
        tot++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL rst0_pc got=%h want=0", bus.out_pc); end
        tot++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL rst0_inst got=%h want=0", bus.out_inst); end
        release_rst();
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b want=1", bus.imem_req); end
        tot++; if (bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL rel_addr got=%h want=%h", bus.imem_addr, RESET_PC); end
        repeat (3) @(negedge clk);
        tot++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b want=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", bus.out_valid); end
        tot++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL async_req got=%b want=0", bus.imem_req); end
        tot++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL async_pc got=%h want=0", bus.out_pc); end
        tot++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL async_inst got=%h want=0", bus.out_inst); end
        release_rst();
    endtask

    task automatic test_stream();
        lat = 1; bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_c0 got=%b want=0", bus.out_valid); end
        @(negedge clk);
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_c1 got=%b want=0", bus.out_valid); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tot++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, bus.out_valid); end
            tot++; if (bus.out_pc !== RESET_PC + 32'(4*i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, bus.out_pc, RESET_PC + 32'(4*i)); end
            tot++; if (bus.out_inst !== inst_of(RESET_PC + 32'(4*i))) begin bad++; $display("FAIL stream_inst[%0d] got=%h want=%h", i, bus.out_inst, inst_of(RESET_PC + 32'(4*i))); end
        end
    endtask

    task automatic test_stall();
        int acc;
        lat = 1; bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
        do_reset();
        acc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) acc++;
        end
        tot++; if (acc != DEPTH) begin bad++; $display("FAIL stall_accepts got=%0d want=%0d", acc, DEPTH); end
        tot++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", bus.imem_req); end
        tot++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", bus.out_valid); end
        tot++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL stall_pc got=%h want=0", bus.out_pc); end
        tot++; if (bus.out_inst !== inst_of(32'h0)) begin bad++; $display("FAIL stall_inst got=%h want=%h", bus.out_inst, inst_of(32'h0)); end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tot++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4*i)) begin bad++; $display("FAIL drain[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.out_pc, 32'(4*i)); end
        end
    endtask

    task automatic test_redirect();
        bit found;
        lat = 3; bus.imem_gnt = 1'b0; bus.out_ready = 1'b1;
        do_reset();
        bus.imem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.imem_gnt    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b want=0", bus.imem_req); end
        tot++; if (pq.size() + int'(bus.imem_rvalid) != 3) begin bad++; $display("FAIL redir_inflight got=%0d want=3", pq.size() + int'(bus.imem_rvalid)); end
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%b/%h want=1/00000100", bus.imem_req, bus.imem_addr); end
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", bus.out_valid); end
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        tot++; if (!found) begin bad++; $display("FAIL redir_timeout got=none want=out_valid"); end
        tot++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h want=00000100", bus.out_pc); end
        tot++; if (bus.out_inst !== inst_of(32'h100)) begin bad++; $display("FAIL redir_inst got=%h want=%h", bus.out_inst, inst_of(32'h100)); end
        @(negedge clk);
        tot++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin bad++; $display("FAIL redir_next got=%b/%h want=1/00000104", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_redirect_align();
        bit found;
        lat = 1; bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL align_addr got=%b/%h want=1/00000200", bus.imem_req, bus.imem_addr); end
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        tot++; if (!found || bus.out_pc !== 32'h200) begin bad++; $display("FAIL align_out got=%b/%h want=1/00000200", found, bus.out_pc); end
    endtask

    task automatic test_gnt_hold();
        logic [31:0] a0;
        bit found;
        @(posedge clk);
        #1 bus.imem_gnt = 1'b0;
        @(negedge clk);
        a0 = bus.imem_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tot++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a0) begin bad++; $display("FAIL hold[%0d] got=%b/%h want=1/%h", i, bus.imem_req, bus.imem_addr, a0); end
        end
        @(posedge clk);
        #1;
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%b/%h want=1/fffffffc", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        tot++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h want=00000000", bus.imem_addr); end
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        tot++; if (!found || bus.out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_out got=%b/%h want=1/fffffffc", found, bus.out_pc); end
        @(negedge clk);
        tot++; if (bus.out_pc !== 32'h0 || bus.out_inst !== inst_of(32'h0)) begin bad++; $display("FAIL wrap_next got=%h/%h want=00000000/%h", bus.out_pc, bus.out_inst, inst_of(32'h0)); end
    endtask

    task automatic test_reset_mid();
        bit found;
        lat = 3; bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && pq.size() + int'(bus.imem_rvalid) == 2) begin found = 1; break; end
        end
        tot++; if (!found) begin bad++; $display("FAIL mid_setup got=none want=2 queued 2 inflight"); end
        #2 rst = 1'b1;
        #1;
        tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.out_valid); end
        tot++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b want=0", bus.imem_req); end
        tot++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin bad++; $display("FAIL mid_out got=%h/%h want=0/0", bus.out_pc, bus.out_inst); end
        lat = 1;
        bus.out_ready = 1'b1;
        release_rst();
        @(negedge clk);
        tot++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_refetch got=%b/%h want=1/%h", bus.imem_req, bus.imem_addr, RESET_PC); end
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        tot++; if (!found) begin bad++; $display("FAIL mid_timeout got=none want=out_valid"); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tot++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC + 32'(4*i) || bus.out_inst !== inst_of(RESET_PC + 32'(4*i))) begin bad++; $display("FAIL mid_seq[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.out_pc, RESET_PC + 32'(4*i)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int pops;
        lat = 2; bus.imem_gnt = 1'b1; bus.out_ready = 1'b1; bus.redirect = 1'b0;
        do_reset();
        exp_pc = RESET_PC;
        pops = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            tot++; if (bus.imem_req === 1'b1 && bus.redirect === 1'b1) begin bad++; $display("FAIL rnd_req_redir c=%0d got=1 want=0", c); end
            tot++; if (bus.imem_req === 1'b1 && pq.size() + int'(bus.imem_rvalid) >= DEPTH) begin bad++; $display("FAIL rnd_credit c=%0d got=%0d want<%0d", c, pq.size() + int'(bus.imem_rvalid), DEPTH); end
            if (bus.redirect === 1'b1) begin
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tot++; if (bus.out_pc !== exp_pc || bus.out_inst !== inst_of(exp_pc)) begin bad++; $display("FAIL rnd_pop c=%0d got=%h/%h want=%h/%h", c, bus.out_pc, bus.out_inst, exp_pc, inst_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            @(posedge clk);
            #1;
            if (c % 64 == 0) lat = $urandom_range(1, 4);
            bus.imem_gnt    = ($urandom_range(0, 99) < 70);
            bus.out_ready   = ($urandom_range(0, 99) < 60);
            bus.redirect    = ($urandom_range(0, 99) < 4);
            bus.redirect_pc = $urandom;
        end
        bus.redirect = 1'b0;
        tot++; if (pops < 80) begin bad++; $display("FAIL rnd_progress got=%0d want>=80", pops); end
    endtask

    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_align();
        test_gnt_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries and maximum outstanding memory requests (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-008 imem_rvalid  input  1  response valid; responses return in request order, latency >=1 cycle.
REQ-009 imem_rdata  input  32  instruction word accompanying imem_rvalid.
REQ-010 redirect  input  1  branch/jump taken from execute; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] forced to 0 internally.
REQ-012 out_valid  output  1  head instruction available to decode register.
REQ-013 out_inst  output  32  head instruction word.
REQ-014 out_pc  output  32  address of out_inst.
REQ-015 out_ready  input  1  decode accepts head (inverse of decode stall); pop on out_valid && out_ready.

Function
REQ-016 fetch_pc register SHALL drive imem_addr and advance by 4 on each accepted request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 imem_req SHALL be 1 iff (fifo_count + outstanding) < DEPTH and redirect == 0 (credit rule; FIFO can never overflow).
REQ-018 While imem_req && !imem_gnt and no redirect, imem_addr SHALL hold stable.
REQ-019 outstanding counter SHALL +1 on accept, -1 on imem_rvalid; both in one cycle -> unchanged.
REQ-020 Accepted, non-squashed response SHALL be written to FIFO tail with resp_pc; resp_pc then advances by 4.
REQ-021 Minimum latency: imem_rvalid in cycle N -> out_valid in cycle N+1 (no combinational bypass).
REQ-022 out_valid SHALL equal (fifo_count != 0); out_inst/out_pc SHALL come from the head entry, registered.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; pop on empty and push on full SHALL not occur (full prevented by REQ-017).
REQ-024 On redirect: FIFO flushed (count 0, pointers reset), fetch_pc and resp_pc <= redirect_pc & ~3, discard_cnt <= outstanding minus any response arriving that cycle; pop in that cycle ignored; response arriving that cycle dropped.
REQ-025 While discard_cnt != 0, each imem_rvalid SHALL be dropped and discard_cnt decremented; discarded responses still decrement outstanding.
REQ-026 Requests SHALL resume the cycle after redirect at redirect_pc; new responses are accepted only after discard_cnt reaches 0 (order guarantee).
REQ-027 Redirect arriving while discard_cnt != 0 SHALL reload discard_cnt from current outstanding (earlier squash subsumed).
REQ-028 imem_rvalid with outstanding == 0 SHALL be ignored and flagged by a simulation assertion.

Reset
REQ-029 rst high SHALL immediately force imem_req 0, out_valid 0, out_inst 0, out_pc 0, fifo_count 0, outstanding 0, discard_cnt 0, fetch_pc and resp_pc RESET_PC.
REQ-030 First rising edge after rst deasserts SHALL see imem_req 1, imem_addr RESET_PC.
REQ-031 rst mid-operation SHALL abandon in-flight responses; responses returning after reset are ignored per REQ-028.

Verification
REQ-032 Reset release, gnt=1, 1-cycle memory, out_ready=1 -> out_pc sequence 0x0,0x4,0x8 on consecutive cycles, one instruction per cycle steady state.
REQ-033 out_ready=0, DEPTH=4, gnt=1 -> exactly 4 requests accepted then imem_req 0; out_valid 1 holding out_pc 0x0; release -> in-order drain 0x0..0xC.
REQ-034 3 requests outstanding, 3-cycle latency, redirect to 0x100 -> 3 responses dropped, next out_pc 0x100 with matching inst, no stale word reaches output.
REQ-035 redirect with redirect_pc 0x203 -> imem_addr 0x200 next cycle.
REQ-036 gnt held low 5 cycles -> imem_addr constant; fetch_pc 0xFFFF_FFFC accepted -> next imem_addr 0x0.
REQ-037 rst asserted with 2 outstanding and 2 FIFO entries -> out_valid 0 same cycle; late responses ignored; refetch from RESET_PC.
